// File: rtl/rm_pipeline_shell_mc.sv
// Multi-retire reference-model pipeline shell: counts retirements, steps the ISS, tags packets with
// pending interrupts and drains them in order to NRET registered lanes. Option: RM_SHELL_IRQ_MASK_EN.
module rm_pipeline_shell_mc #(
    parameter int unsigned NRET  = 2,
    parameter int unsigned IRQ_W = 32,
    parameter int unsigned PKT_W = 512,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NRET-1:0]         core_valid_i,
    input  logic [IRQ_W-1:0]        irq_i,
`ifdef RM_SHELL_IRQ_MASK_EN
    input  logic [IRQ_W-1:0]        irq_mask_i,
`endif
    output logic                    iss_irq_upd_o,
    output logic [IRQ_W-1:0]        iss_irq_o,
    output logic                    iss_step_req_o,
    input  logic                    iss_step_ack_i,
    input  logic [PKT_W-1:0]        iss_pkt_i,
    output logic [NRET-1:0]         rm_valid_o,
    output logic [NRET*PKT_W-1:0]   rm_pkt_o,
    output logic [NRET-1:0]         rm_intr_o,
    output logic [NRET*11-1:0]      rm_cause_o,
    output logic                    overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned SW = CNT_W + 4;

    logic [CNT_W-1:0] cnt_q;
    logic             overflow_q;
    logic [IRQ_W-1:0] irq_q;
    logic             pend_q;
    logic [10:0]      cause_q;
    logic [PW-1:0]    wptr_q, rptr_q;

    logic [PKT_W-1:0] pkt_mem   [DEPTH];
    logic             intr_mem  [DEPTH];
    logic [10:0]      cause_mem [DEPTH];

    logic [NRET-1:0]       valid_q;
    logic [NRET*PKT_W-1:0] pkt_q;
    logic [NRET-1:0]       intr_q;
    logic [NRET*11-1:0]    cause_out_q;

    logic [IRQ_W-1:0] irq_eff;
    logic             irq_chg;
    logic [10:0]      low_idx;
    logic [3:0]       pop_cnt;
    logic [SW-1:0]    cnt_sum;
    logic [PW-1:0]    fifo_count;
    logic [PW-1:0]    n_pop;
    logic             push;

    logic [NRET-1:0]       valid_d;
    logic [NRET*PKT_W-1:0] pkt_d;
    logic [NRET-1:0]       intr_d;
    logic [NRET*11-1:0]    cause_d;

`ifdef RM_SHELL_IRQ_MASK_EN
    assign irq_eff = irq_i & irq_mask_i;
`else
    assign irq_eff = irq_i;
`endif

    assign irq_chg       = irq_eff != irq_q;
    // Gated with reset so the update strobe stays low while the shell is held in reset.
    assign iss_irq_upd_o = irq_chg & rst_ni;
    assign iss_irq_o     = (irq_chg & rst_ni) ? irq_eff : '0;

    assign fifo_count     = wptr_q - rptr_q;
    assign iss_step_req_o = (cnt_q != '0) && (fifo_count != PW'(DEPTH));
    assign push           = iss_step_req_o & iss_step_ack_i;

    always_comb begin
        low_idx = '0;
        for (int i = int'(IRQ_W) - 1; i >= 0; i--) begin
            if (irq_eff[i]) low_idx = 11'(i);
        end
    end

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < int'(NRET); i++) begin
            pop_cnt = pop_cnt + 4'(core_valid_i[i]);
        end
        cnt_sum = SW'(cnt_q) + SW'(pop_cnt) - SW'(push);
    end

    always_comb begin
        if (int'(fifo_count) > int'(NRET)) n_pop = PW'(NRET);
        else                                n_pop = fifo_count;
    end

    // Only entries present in registered state are drained, so a fresh push waits one cycle.
    always_comb begin
        valid_d = '0;
        pkt_d   = '0;
        intr_d  = '0;
        cause_d = '0;
        for (int i = 0; i < int'(NRET); i++) begin
            if (i < int'(n_pop)) begin
                valid_d[i]              = 1'b1;
                pkt_d[i*PKT_W +: PKT_W] = pkt_mem[AW'(rptr_q + PW'(i))];
                intr_d[i]               = intr_mem[AW'(rptr_q + PW'(i))];
                cause_d[i*11 +: 11]     = cause_mem[AW'(rptr_q + PW'(i))];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            pkt_mem[wptr_q[AW-1:0]]   <= iss_pkt_i;
            intr_mem[wptr_q[AW-1:0]]  <= pend_q;
            cause_mem[wptr_q[AW-1:0]] <= pend_q ? cause_q : 11'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
            irq_q       <= '0;
            pend_q      <= 1'b0;
            cause_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            valid_q     <= '0;
            pkt_q       <= '0;
            intr_q      <= '0;
            cause_out_q <= '0;
        end else begin
            if (cnt_sum > SW'({CNT_W{1'b1}})) begin
                cnt_q      <= '1;
                overflow_q <= 1'b1;
            end else begin
                cnt_q <= cnt_sum[CNT_W-1:0];
            end
            irq_q <= irq_eff;
            // A newly raised interrupt outranks the clear so it tags the next push.
            if (irq_chg && (irq_eff != '0)) begin
                pend_q  <= 1'b1;
                cause_q <= low_idx;
            end else if (push) begin
                pend_q <= 1'b0;
            end
            wptr_q      <= wptr_q + PW'(push);
            rptr_q      <= rptr_q + n_pop;
            valid_q     <= valid_d;
            pkt_q       <= pkt_d;
            intr_q      <= intr_d;
            cause_out_q <= cause_d;
        end
    end

    assign rm_valid_o = valid_q;
    assign rm_pkt_o   = pkt_q;
    assign rm_intr_o  = intr_q;
    assign rm_cause_o = cause_out_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_rm_pipeline_shell_mc.sv
// Scoreboard bench for rm_pipeline_shell_mc: handshakes push expected packets, a lane monitor pops.
module tb_rm_pipeline_shell_mc;

    localparam int unsigned NRET  = 2;
    localparam int unsigned IRQ_W = 32;
    localparam int unsigned PKT_W = 64;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NRET-1:0]       core_valid;
    logic [IRQ_W-1:0]      irq;
    logic [IRQ_W-1:0]      irq_mask;
    logic                  upd;
    logic [IRQ_W-1:0]      iss_irq;
    logic                  req;
    logic                  ack;
    logic [PKT_W-1:0]      pkt_ctr;
    logic [NRET-1:0]       rm_valid;
    logic [NRET*PKT_W-1:0] rm_pkt;
    logic [NRET-1:0]       rm_intr;
    logic [NRET*11-1:0]    rm_cause;
    logic                  overflow;

    always #5 clk = ~clk;

    rm_pipeline_shell_mc #(
        .NRET (NRET),
        .IRQ_W(IRQ_W),
        .PKT_W(PKT_W),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .core_valid_i  (core_valid),
        .irq_i         (irq),
`ifdef RM_SHELL_IRQ_MASK_EN
        .irq_mask_i    (irq_mask),
`endif
        .iss_irq_upd_o (upd),
        .iss_irq_o     (iss_irq),
        .iss_step_req_o(req),
        .iss_step_ack_i(ack),
        .iss_pkt_i     (pkt_ctr),
        .rm_valid_o    (rm_valid),
        .rm_pkt_o      (rm_pkt),
        .rm_intr_o     (rm_intr),
        .rm_cause_o    (rm_cause),
        .overflow_o    (overflow)
    );

    typedef struct packed {
        logic [PKT_W-1:0] pkt;
        logic             intr;
        logic [10:0]      cause;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_push   = 0;
    int          n_out    = 0;
    logic        tb_pend  = 1'b0;
    logic [10:0] tb_cause = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Stimulus side of the scoreboard: every accepted step pushes the packet the bench supplied.
    always @(negedge clk) begin
        if (rst_n && req && ack) begin
            exp_q.push_back('{pkt: pkt_ctr, intr: tb_pend, cause: (tb_pend ? tb_cause : 11'd0)});
            tb_pend = 1'b0;
            n_push++;
        end
    end

    always @(posedge clk) begin
        if (rst_n && req && ack) pkt_ctr <= pkt_ctr + 64'd1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < int'(NRET); i++) begin
                if (rm_valid[i]) begin
                    if (i > 0) check("lane_contiguous", 64'(rm_valid[i-1]), 64'd1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL spurious_valid lane %0d: got valid=1 pkt=%0h, required valid=0",
                                 i, rm_pkt[i*PKT_W +: PKT_W]);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("lane_pkt", 64'(rm_pkt[i*PKT_W +: PKT_W]), 64'(e.pkt));
                        check("lane_intr", 64'(rm_intr[i]), 64'(e.intr));
                        check("lane_cause", 64'(rm_cause[i*11 +: 11]), 64'(e.cause));
                        n_out++;
                    end
                end else begin
                    check("idle_lane_zero",
                          64'(rm_pkt[i*PKT_W +: PKT_W]) | 64'({rm_intr[i], rm_cause[i*11 +: 11]}),
                          64'd0);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        core_valid = '0;
        ack        = 1'b0;
        irq        = '0;
        cycles(2);
        exp_q.delete();
        tb_pend = 1'b0;
        rst_n   = 1'b1;
        cycles(1);
    endtask

    // Drives a new irq value, expects a one-cycle update pulse carrying it.
    task automatic irq_step(input logic [IRQ_W-1:0] v, input logic exp_pulse);
        irq = v;
        @(negedge clk);
        check("irq_upd_pulse", 64'(upd), 64'(exp_pulse));
        check("irq_vector", 64'(iss_irq), exp_pulse ? 64'(v) : 64'd0);
        cycles(1);
        @(negedge clk);
        check("irq_upd_single", 64'(upd), 64'd0);
        cycles(1);
    endtask

    int base_push, base_out;

    initial begin
        pkt_ctr    = 64'hA000;
        irq_mask   = '1;
        rst_n      = 1'b0;
        core_valid = '0;
        ack        = 1'b0;
        irq        = '0;
        #1;
        check("reset_valid", 64'(rm_valid), 64'd0);
        check("reset_req", 64'(req), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        do_reset();

        // Two retirements at once, ack always high.
        base_push = n_push; base_out = n_out;
        core_valid = 2'b11; ack = 1'b1;
        cycles(1);
        core_valid = '0;
        cycles(10);
        check("t1_pushes", 64'(n_push - base_push), 64'd2);
        check("t1_outs", 64'(n_out - base_out), 64'd2);

        // Backlog of ten steps with ack held low.
        base_push = n_push; base_out = n_out;
        ack = 1'b0; core_valid = 2'b11;
        cycles(5);
        core_valid = '0;
        @(negedge clk);
        check("t2_req_held", 64'(req), 64'd1);
        check("t2_no_push", 64'(n_push - base_push), 64'd0);
        check("t2_no_overflow", 64'(overflow), 64'd0);
        cycles(1);
        ack = 1'b1;
        cycles(20);
        check("t2_pushes", 64'(n_push - base_push), 64'd10);
        check("t2_outs", 64'(n_out - base_out), 64'd10);
        check("t2_req_idle", 64'(req), 64'd0);

        // Interrupt 0x808: lowest set bit 3 tags only the next packet.
        base_out = n_out;
        irq_step(32'h0000_0808, 1'b1);
        tb_pend = 1'b1; tb_cause = 11'd3;
        core_valid = 2'b11;
        cycles(1);
        core_valid = '0;
        cycles(10);
        check("t3_outs", 64'(n_out - base_out), 64'd2);

        // 0 -> 8 -> 0: two pulses, the fall to zero leaves the pending tag intact.
        irq_step(32'h0, 1'b1);
        base_out = n_out;
        irq_step(32'h8, 1'b1);
        tb_pend = 1'b1; tb_cause = 11'd3;
        irq_step(32'h0, 1'b1);
        core_valid = 2'b01;
        cycles(1);
        core_valid = '0;
        cycles(8);
        check("t4_outs", 64'(n_out - base_out), 64'd1);

        // Saturation of the 4-bit step counter.
        base_push = n_push; base_out = n_out;
        ack = 1'b0; core_valid = 2'b01;
        cycles(15);
        @(negedge clk);
        check("t5_no_overflow_at_max", 64'(overflow), 64'd0);
        cycles(1);
        core_valid = '0;
        @(negedge clk);
        check("t5_overflow_set", 64'(overflow), 64'd1);
        cycles(1);
        ack = 1'b1;
        cycles(30);
        check("t5_pushes_saturated", 64'(n_push - base_push), 64'd15);
        check("t5_outs", 64'(n_out - base_out), 64'd15);
        check("t5_overflow_sticky", 64'(overflow), 64'd1);

        // Reset in the middle of draining.
        ack = 1'b0; core_valid = 2'b11;
        cycles(3);
        core_valid = '0; ack = 1'b1;
        cycles(2);
        rst_n = 1'b0;
        #1;
        check("t6_valid_cleared", 64'(rm_valid), 64'd0);
        check("t6_pkt_cleared", 64'(|rm_pkt), 64'd0);
        check("t6_intr_cause_cleared", 64'({rm_intr, rm_cause}), 64'd0);
        check("t6_req_cleared", 64'(req), 64'd0);
        check("t6_overflow_cleared", 64'(overflow), 64'd0);
        check("t6_upd_cleared", 64'(upd), 64'd0);
        cycles(2);
        exp_q.delete();
        tb_pend = 1'b0;
        rst_n = 1'b1;
        base_push = n_push; base_out = n_out;
        cycles(20);
        check("t6_no_push_after_reset", 64'(n_push - base_push), 64'd0);
        check("t6_no_out_after_reset", 64'(n_out - base_out), 64'd0);
        core_valid = 2'b10;
        cycles(1);
        core_valid = '0;
        cycles(8);
        check("t6_resume_outs", 64'(n_out - base_out), 64'd1);

`ifdef RM_SHELL_IRQ_MASK_EN
        // Fully masked interrupt: no pulse, no tag.
        base_out = n_out;
        irq_mask = '0;
        irq_step(32'h80, 1'b0);
        core_valid = 2'b01;
        cycles(1);
        core_valid = '0;
        cycles(8);
        check("t7_masked_outs", 64'(n_out - base_out), 64'd1);
`endif

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
